// File: rtl/fc_pkg.sv
//-----------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the FC training sequencer slice.
//   - state_t      : sequencer phases for one training sample
//   - BANK_RAM*    : memory bank-select codes {fc1_com_end, fc2_com_end}
//   - ONE_FX       : fixed-point 1.0 used as the correct-class target
//   - ADDR_W/DATA_W: memory write-port widths
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
package fc_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] ONE_FX = 16'h0400;

  localparam logic [1:0] BANK_RAM0 = 2'b00;
  localparam logic [1:0] BANK_RAM1 = 2'b10;
  localparam logic [1:0] BANK_RAM2 = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    CONV,
    FC1,
    FC2,
    LABEL,
    BPROP,
    BGAP,
    UPDATE,
    UGAP
  } state_t;

endpackage

// File: rtl/fc_wr_mux.sv
//-----------------------------------------------------------------------------
// fc_wr_mux
// Combinational three-source arbiter for the single FC memory write port.
// The sequencer state alone decides the owner; a request from any other
// source is simply dropped.
// Ports:
//   state                       : current sequencer state
//   conv_we/conv_addr/conv_data : conv engine request (owner in CONV)
//   fc_we/fc_addr/fc_data       : FC engine request (owner in FC1/FC2)
//   lbl_we/lbl_addr/lbl_data    : internal label writer (owner in LABEL)
//   mem_we/mem_addr/mem_data    : muxed memory write port
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module fc_wr_mux
  import fc_pkg::*;
(
  input  state_t            state,
  input  logic              conv_we,
  input  logic [ADDR_W-1:0] conv_addr,
  input  logic [DATA_W-1:0] conv_data,
  input  logic              fc_we,
  input  logic [ADDR_W-1:0] fc_addr,
  input  logic [DATA_W-1:0] fc_data,
  input  logic              lbl_we,
  input  logic [ADDR_W-1:0] lbl_addr,
  input  logic [DATA_W-1:0] lbl_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data
);

  // Pick the write owner from the state. States with no owner drive an
  // all-zero port so the memory never sees stale addresses or data.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    case (state)
      CONV: begin
        mem_we   = conv_we;
        mem_addr = conv_addr;
        mem_data = conv_data;
      end
      FC1, FC2: begin
        mem_we   = fc_we;
        mem_addr = fc_addr;
        mem_data = fc_data;
      end
      LABEL: begin
        mem_we   = lbl_we;
        mem_addr = lbl_addr;
        mem_data = lbl_data;
      end
      default: begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/fc_train_sequencer.sv
//-----------------------------------------------------------------------------
// fc_train_sequencer
// Walks one training sample through the FC memory/backprop block:
// conv load -> FC1 -> FC2 -> one-hot label write -> backprop, and after
// BATCH_SIZE samples runs the weight update.
// Ports:
//   clk, reset (synchronous, active high)
//   start, label                 : begin a sample (IDLE only), class index
//   conv_done/fc1_done/fc2_done  : phase-complete pulses
//   conv_* / fc_*                : engine write requests
//   fc_bck_prop_end/fc_batch_end : completion levels from the memory
//   mem_we/mem_addr/mem_data     : arbitrated memory write port
//   fc1_com_end/fc2_com_end      : registered bank selects
//   bck_prop_start/batch_end     : level handshakes toward the memory
//   busy, sample_done, batch_done, batch_cnt : status
//   seq_err                      : sticky watchdog error
// Optional feature macro: FC_SEQ_TIMEOUT_EN enables a per-phase watchdog of
// TIMEOUT_CYC cycles; without it seq_err is tied low.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module fc_train_sequencer #(
  parameter int BCK_CELL   = 10,
  parameter int BATCH_SIZE = 32,
`ifdef FC_SEQ_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 4096,
`endif
  parameter logic [15:0] ONE_FX = fc_pkg::ONE_FX
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [3:0]                label,
  input  logic                      conv_done,
  input  logic                      fc1_done,
  input  logic                      fc2_done,
  input  logic                      conv_we,
  input  logic [fc_pkg::ADDR_W-1:0] conv_addr,
  input  logic [fc_pkg::DATA_W-1:0] conv_data,
  input  logic                      fc_we,
  input  logic [fc_pkg::ADDR_W-1:0] fc_addr,
  input  logic [fc_pkg::DATA_W-1:0] fc_data,
  input  logic                      fc_bck_prop_end,
  input  logic                      fc_batch_end,
  output logic                      mem_we,
  output logic [fc_pkg::ADDR_W-1:0] mem_addr,
  output logic [fc_pkg::DATA_W-1:0] mem_data,
  output logic                      fc1_com_end,
  output logic                      fc2_com_end,
  output logic                      bck_prop_start,
  output logic                      batch_end,
  output logic                      busy,
  output logic                      sample_done,
  output logic                      batch_done,
  output logic [4:0]                batch_cnt,
  output logic                      seq_err
);

  import fc_pkg::*;

  localparam logic [3:0] K_LAST   = 4'(BCK_CELL - 1);
  localparam logic [4:0] CNT_LAST = 5'(BATCH_SIZE - 1);

  state_t            state;
  logic [3:0]        label_q;
  logic [3:0]        k_cnt;
  logic              timeout_hit;
  logic [ADDR_W-1:0] lbl_addr;
  logic [DATA_W-1:0] lbl_data;

  // Label writer: word k lands at BCK_CELL+k and carries 1.0 only for the
  // correct class. An out-of-range label never matches k, so every word is 0.
  always_comb begin
    lbl_addr = ADDR_W'(BCK_CELL) + ADDR_W'(k_cnt);
    lbl_data = (k_cnt == label_q) ? ONE_FX : '0;
  end

  // Write-port arbitration lives in its own combinational block.
  fc_wr_mux u_wr_mux (
    .state     (state),
    .conv_we   (conv_we),
    .conv_addr (conv_addr),
    .conv_data (conv_data),
    .fc_we     (fc_we),
    .fc_addr   (fc_addr),
    .fc_data   (fc_data),
    .lbl_we    (state == LABEL),
    .lbl_addr  (lbl_addr),
    .lbl_data  (lbl_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

`ifdef FC_SEQ_TIMEOUT_EN
  localparam int PH_W = $clog2(TIMEOUT_CYC + 1);

  logic [PH_W-1:0] phase_cnt;
  logic            phase_wait;
  logic            phase_adv;

  // A phase "waits" when it depends on an external event; the counter only
  // runs there and restarts whenever the awaited event moves the state on.
  always_comb begin
    phase_wait = 1'b0;
    phase_adv  = 1'b1;
    case (state)
      CONV:    begin phase_wait = 1'b1; phase_adv = conv_done;       end
      FC1:     begin phase_wait = 1'b1; phase_adv = fc1_done;        end
      FC2:     begin phase_wait = 1'b1; phase_adv = fc2_done;        end
      BPROP:   begin phase_wait = 1'b1; phase_adv = fc_bck_prop_end; end
      UPDATE:  begin phase_wait = 1'b1; phase_adv = fc_batch_end;    end
      default: begin phase_wait = 1'b0; phase_adv = 1'b1;            end
    endcase
    timeout_hit = phase_wait && !phase_adv &&
                  (phase_cnt == PH_W'(TIMEOUT_CYC - 1));
  end

  // Phase watchdog counter and its sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt <= '0;
      seq_err   <= 1'b0;
    end else if (timeout_hit) begin
      phase_cnt <= '0;
      seq_err   <= 1'b1;
    end else if (!phase_wait || phase_adv) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign seq_err     = 1'b0;
`endif

  // Main sequencer. Every registered output is updated on the same edge as
  // the state it belongs to, so bank selects and handshakes never lag the
  // state by a cycle. sample_done/batch_done default low to form pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      label_q        <= '0;
      k_cnt          <= '0;
      batch_cnt      <= '0;
      fc1_com_end    <= 1'b0;
      fc2_com_end    <= 1'b0;
      bck_prop_start <= 1'b0;
      batch_end      <= 1'b0;
      busy           <= 1'b0;
      sample_done    <= 1'b0;
      batch_done     <= 1'b0;
    end else if (timeout_hit) begin
      state          <= IDLE;
      k_cnt          <= '0;
      fc1_com_end    <= 1'b0;
      fc2_com_end    <= 1'b0;
      bck_prop_start <= 1'b0;
      batch_end      <= 1'b0;
      busy           <= 1'b0;
      sample_done    <= 1'b0;
      batch_done     <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      batch_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            label_q <= label;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          if (conv_done) begin
            {fc1_com_end, fc2_com_end} <= BANK_RAM1;
            state <= FC1;
          end
        end
        FC1: begin
          if (fc1_done) begin
            {fc1_com_end, fc2_com_end} <= BANK_RAM2;
            state <= FC2;
          end
        end
        FC2: begin
          if (fc2_done) begin
            k_cnt <= '0;
            state <= LABEL;
          end
        end
        LABEL: begin
          if (k_cnt == K_LAST) begin
            k_cnt          <= '0;
            bck_prop_start <= 1'b1;
            state          <= BPROP;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        BPROP: begin
          // The batch decision is made here; a non-final sample already
          // shows its incremented count and sample_done during the gap.
          if (fc_bck_prop_end) begin
            bck_prop_start <= 1'b0;
            if (batch_cnt != CNT_LAST) begin
              batch_cnt   <= batch_cnt + 1'b1;
              sample_done <= 1'b1;
            end
            state <= BGAP;
          end
        end
        BGAP: begin
          // sample_done high here means the batch is not yet complete.
          {fc1_com_end, fc2_com_end} <= BANK_RAM0;
          if (sample_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            batch_end <= 1'b1;
            state     <= UPDATE;
          end
        end
        UPDATE: begin
          if (fc_batch_end) begin
            batch_end   <= 1'b0;
            batch_cnt   <= '0;
            sample_done <= 1'b1;
            batch_done  <= 1'b1;
            state       <= UGAP;
          end
        end
        UGAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          {fc1_com_end, fc2_com_end} <= BANK_RAM0;
          bck_prop_start <= 1'b0;
          batch_end      <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fc_train_sequencer.md
Name: fc_train_sequencer

Overview:
Sequences one training sample at a time through the FC memory/backprop block: conv-result load, FC1 compute, FC2 compute, one-hot label write, back propagation, and end-of-batch weight update.
- Drives the memory bank-select pair (fc1_com_end, fc2_com_end), bck_prop_start and batch_end.
- Arbitrates the single memory write port between the conv engine, the FC compute engine and its own label writer.
- Counts mini-batch samples up to BATCH_SIZE.

Parameters:
- BCK_CELL, 10, output-layer cells; label words written per sample.
- BATCH_SIZE, 32, samples per weight update.
- ONE_FX, 16'h0400, fixed-point 1.0 written as the correct-class target.
- TIMEOUT_CYC, 4096, watchdog limit per phase (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin one sample; accepted only in IDLE.
- label  in  4  correct class index 0..BCK_CELL-1; sampled with start.
- conv_done  in  1  pulse: conv results written.
- fc1_done  in  1  pulse: FC1 results written.
- fc2_done  in  1  pulse: FC2 results written.
- conv_we / conv_addr / conv_data  in  1/16/16  conv engine write request.
- fc_we / fc_addr / fc_data  in  1/16/16  FC engine write request.
- fc_bck_prop_end  in  1  from memory: backprop finished.
- fc_batch_end  in  1  from memory: weight update finished.
- mem_we / mem_addr / mem_data  out  1/16/16  muxed memory write port.
- fc1_com_end  out  1  bank select bit 1.
- fc2_com_end  out  1  bank select bit 0.
- bck_prop_start  out  1  level; held high through backprop.
- batch_end  out  1  level; held high through weight update.
- busy  out  1  high whenever the FSM is not in IDLE.
- sample_done  out  1  one-cycle pulse at the end of each sample.
- batch_done  out  1  one-cycle pulse after the weight update.
- batch_cnt  out  5  samples completed in the current batch.
- seq_err  out  1  sticky watchdog error (optional feature only).

Behaviour:
- Reset (synchronous, active-high): state IDLE, batch_cnt=0, label register=0.
  - All outputs 0.
  - A reset during BPROP or UPDATE abandons the operation; the memory's accumulated deltas are not cleared by this block.
- States and bank selects {fc1_com_end, fc2_com_end}:
  - IDLE 00: start=1 registers label and moves to CONV. start outside IDLE is ignored.
  - CONV 00: conv_* passed through to mem_*; conv_done -> FC1.
  - FC1 10: fc_* passed through; fc1_done -> FC2.
  - FC2 11: fc_* passed through; fc2_done -> LABEL.
  - LABEL 11: internal writer, counter k=0..BCK_CELL-1, one word per cycle.
    - mem_we=1, mem_addr=BCK_CELL+k.
    - mem_data = ONE_FX when k==label, else 0.
    - After k=BCK_CELL-1 -> BPROP. Duration is exactly BCK_CELL cycles.
  - BPROP 11: bck_prop_start=1 until fc_bck_prop_end=1 is sampled, then -> BGAP.
  - BGAP 11: bck_prop_start=0 for exactly 1 cycle so the memory re-arms its indices.
    - If batch_cnt==BATCH_SIZE-1: -> UPDATE.
    - Otherwise: batch_cnt+1, sample_done=1, -> IDLE.
  - UPDATE 00: batch_end=1 until fc_batch_end=1 is sampled, then -> UGAP.
  - UGAP 00: batch_end=0; batch_cnt=0; sample_done=1 and batch_done=1 in the same cycle; -> IDLE.
- Write-port mux:
  - Combinational, zero latency.
  - In states without a write owner (IDLE, BPROP, BGAP, UPDATE, UGAP): mem_we=0, mem_addr/mem_data=0.
  - Requests from a non-owning requester are dropped, not queued.
- A done pulse arriving in the wrong state is ignored.
- label>=BCK_CELL: all label words are written as 0; no error is raised.
- Bank selects are registered, so they change on the same edge as the state.

Optional Feature:
- Macro FC_SEQ_TIMEOUT_EN.
- Defined:
  - A phase counter clears on every state change and increments in CONV/FC1/FC2/BPROP/UPDATE.
  - When it reaches TIMEOUT_CYC: seq_err=1 (sticky until reset), all outputs forced low, state -> IDLE, batch_cnt preserved.
- Undefined: no counter; seq_err is tied to 0.

Decomposition:
- Shared package fc_pkg holds:
  - state enum (IDLE, CONV, FC1, FC2, LABEL, BPROP, BGAP, UPDATE, UGAP);
  - bank-select constants BANK_RAM0=2'b00, BANK_RAM1=2'b10, BANK_RAM2=2'b11;
  - ONE_FX;
  - the address-width constant 16.
- One sub-module, fc_wr_mux: the combinational 3-source write-port mux selected by state.

Test Plan:
- Single sample, label=3: start -> conv_done -> fc1_done -> fc2_done.
  - Expect banks 00, 10, 11 in order.
  - Expect 10 label writes to addr 10..19, with data 16'h0400 only at addr 13.
  - Expect BPROP; fc_bck_prop_end after 700 cycles -> 1-cycle bck_prop_start low, sample_done, batch_cnt=1.
- 32 samples back-to-back: on the 32nd, UPDATE has batch_end high until fc_batch_end.
  - Then batch_end is low 1 cycle, batch_done=1, batch_cnt=0.
- Arbitration: in FC1 drive conv_we=1 at addr 5 and fc_we=1 at addr 7 -> only addr 7 is written. In IDLE, fc_we=1 -> mem_we=0.
- Stray events: fc2_done during CONV and start during BPROP -> no state change.
- Reset asserted mid-BPROP at sample 5 -> next cycle IDLE, all outputs 0, batch_cnt=0.
- With FC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16: withhold fc1_done -> seq_err=1 after 16 cycles in FC1, state IDLE, seq_err stays high until reset.
